axis_rr_packet_arbiter: RTL and testbench
=========================================

Name: axis_rr_packet_arbiter

Overview:
- Packet-level round-robin arbiter/mux that shares one AXI-Stream transmitter port between N AXI-Stream receiver ports.
- Once granted, an input owns the output until its tlast beat transfers. Packets are never interleaved.
- Sits between per-source frame generators (UDP/ARP/ICMP builders) and the single MAC TX stream.

Parameters:
- N_INPUTS, 4, number of requesting streams; legal range 2..16.
- TDATA_WIDTH, 8, tdata width in bits; multiple of 8.
- TUSER_WIDTH, 1, tuser width in bits; must be ≥1.
- IDX_WIDTH, $clog2(N_INPUTS), width of grant index; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset. Deassertion is synchronised externally.
- s_tvalid  in  N_INPUTS  per-input valid.
- s_tready  out  N_INPUTS  per-input ready.
- s_tdata  in  N_INPUTS*TDATA_WIDTH  packed; input i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_tkeep  in  N_INPUTS*(TDATA_WIDTH/8)  packed per input.
- s_tlast  in  N_INPUTS  per-input end of packet.
- s_tuser  in  N_INPUTS*TUSER_WIDTH  packed per input.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  TDATA_WIDTH  muxed data.
- m_tkeep  out  TDATA_WIDTH/8  muxed keep.
- m_tlast  out  1  muxed last.
- m_tuser  out  TUSER_WIDTH  muxed user.
- busy  out  1  high while a packet is locked.
- grant_idx  out  IDX_WIDTH  current or most recent owner.

Behaviour:
- Reset (async assert):
  - state=IDLE, rr_ptr=0, grant_idx=0, busy=0.
  - m_tvalid=0, all s_tready=0.
  - The outputs listed above are forced to these values for as long as rst_n is low.
- State IDLE:
  - m_tvalid=0 and s_tready=0 for all inputs.
  - Search starts at rr_ptr and wraps modulo N_INPUTS. The first i with s_tvalid[i]=1 wins.
  - On the next edge: grant_idx<=i, state<=LOCKED, busy<=1.
  - If no input is valid, stay in IDLE.
- State LOCKED (g=grant_idx):
  - Combinational pass-through with zero added latency:
    - m_tvalid=s_tvalid[g]; m_tdata/m_tkeep/m_tlast/m_tuser come from input g.
    - s_tready[g]=m_tready; s_tready[j≠g]=0.
  - A beat transfers when m_tvalid&&m_tready.
  - A transfer with m_tlast=1 moves to IDLE on the next edge. It also sets rr_ptr<=(g+1) mod N_INPUTS and busy<=0.
- Arbitration cadence:
  - One IDLE bubble cycle always separates packets.
  - Minimum cost per packet is 1 + beat count cycles.
- Fairness: with all inputs continuously valid, grants rotate 0,1,2,…,N-1,0. No input waits longer than N_INPUTS-1 packets.
- m_tready deasserted in LOCKED: hold the state. AXIS stability of held data is the source's responsibility.
- Source drops tvalid mid-packet: stay LOCKED (gap tolerated). The arbiter never re-arbitrates before tlast.
- Single-beat packet (tlast on first beat): LOCKED lasts exactly one transfer cycle.
- Reset asserted mid-packet: immediate return to the reset state. The partial packet is abandoned; downstream framing recovery is the MAC's concern.
- rr_ptr wrap: (N_INPUTS-1)+1 wraps to 0. The wrap must be correct for non-power-of-2 N_INPUTS.
- grant_idx holds its value in IDLE (last owner) for debug.
- Outputs outside LOCKED: m_tdata/m_tkeep/m_tlast/m_tuser are don't-care when m_tvalid=0. Drive them from input grant_idx to avoid extra muxing.

Optional Feature:
- Macro AXIS_ARB_TID_EN.
- When defined:
  - Add output port m_tid, IDX_WIDTH wide, equal to grant_idx.
  - m_tid is valid whenever m_tvalid=1, so downstream logic can demux or account per source.
- When undefined: the port is absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, all s_tvalid=0 → m_tvalid=0, s_tready=0, busy=0, grant_idx=0 throughout.
- Single requester: input 2 sends a 4-beat packet 0xA0..0xA3 (tlast on 0xA3), m_tready=1.
  - Grant after 1 cycle; beats appear at m_tdata on 4 consecutive cycles.
  - busy falls after 0xA3; rr_ptr=3.
- Round robin: all 4 inputs hold 2-beat packets continuously valid → output packet order is 0,1,2,3,0. Each packet is separated by exactly one m_tvalid=0 cycle.
- No interleave under backpressure: input 1 is locked mid-packet, m_tready toggles 1,0,0,1, and input 0 asserts valid → input 0's s_tready stays 0. The remaining beats of input 1 complete first, then input 0 is granted.
- Mid-packet reset: assert rst_n low during beat 2 of a 5-beat packet → m_tvalid=0 and s_tready=0 within the same cycle. After release, arbitration restarts from rr_ptr=0.
- TID (AXIS_ARB_TID_EN): input 3 sends one beat with tlast=1 → m_tid=3 on that beat; the next grant rotates to input 0.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: N sources share one sink, never interleaving packets.
// Optional `define AXIS_ARB_TID_EN adds m_tid (source index of the current beat).
module axis_rr_packet_arbiter #(
  parameter int N_INPUTS    = 4,
  parameter int TDATA_WIDTH = 8,
  parameter int TUSER_WIDTH = 1,
  parameter int IDX_WIDTH   = $clog2(N_INPUTS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_INPUTS-1:0]                s_tvalid,
  output logic [N_INPUTS-1:0]                s_tready,
  input  logic [N_INPUTS*TDATA_WIDTH-1:0]    s_tdata,
  input  logic [N_INPUTS*(TDATA_WIDTH/8)-1:0] s_tkeep,
  input  logic [N_INPUTS-1:0]                s_tlast,
  input  logic [N_INPUTS*TUSER_WIDTH-1:0]    s_tuser,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic [TDATA_WIDTH-1:0]             m_tdata,
  output logic [TDATA_WIDTH/8-1:0]           m_tkeep,
  output logic                               m_tlast,
  output logic [TUSER_WIDTH-1:0]             m_tuser,
  output logic                               busy,
  output logic [IDX_WIDTH-1:0]               grant_idx
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [IDX_WIDTH-1:0]               m_tid
`endif
);

  localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_reg, state_next;
  logic [IDX_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDX_WIDTH-1:0] grant_idx_reg, grant_idx_next;
  logic                 busy_reg, busy_next;

  logic                 req_any;
  logic [IDX_WIDTH-1:0] req_idx;
  logic [IDX_WIDTH:0]   cand_sum;

  logic [TDATA_WIDTH-1:0] data_arr [N_INPUTS];
  logic [KEEP_WIDTH-1:0]  keep_arr [N_INPUTS];
  logic [TUSER_WIDTH-1:0] user_arr [N_INPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
      assign data_arr[gi] = s_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH];
      assign keep_arr[gi] = s_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
      assign user_arr[gi] = s_tuser[gi*TUSER_WIDTH +: TUSER_WIDTH];
    end
  endgenerate

  // Rotating search from rr_ptr; explicit subtract keeps the wrap exact for non-power-of-2 N.
  always_comb begin
    req_any  = 1'b0;
    req_idx  = rr_ptr_reg;
    cand_sum = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (IDX_WIDTH+1)'(k);
      if (cand_sum >= (IDX_WIDTH+1)'(N_INPUTS))
        cand_sum = cand_sum - (IDX_WIDTH+1)'(N_INPUTS);
      if (!req_any && s_tvalid[cand_sum[IDX_WIDTH-1:0]]) begin
        req_any = 1'b1;
        req_idx = cand_sum[IDX_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_idx_reg <= grant_idx_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_idx_next = grant_idx_reg;
    busy_next      = busy_reg;
    case (state_reg)
      IDLE: begin
        if (req_any) begin
          state_next     = LOCKED;
          grant_idx_next = req_idx;
          busy_next      = 1'b1;
        end
      end
      LOCKED: begin
        // Only the tlast handshake releases ownership; gaps and backpressure just hold.
        if (m_tvalid && m_tready && m_tlast) begin
          state_next  = IDLE;
          busy_next   = 1'b0;
          rr_ptr_next = (grant_idx_reg == IDX_WIDTH'(N_INPUTS-1)) ? '0 : grant_idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Payload always comes from grant_idx so the mux select never changes outside a grant.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = data_arr[grant_idx_reg];
    m_tkeep  = keep_arr[grant_idx_reg];
    m_tlast  = s_tlast[grant_idx_reg];
    m_tuser  = user_arr[grant_idx_reg];
    if (state_reg == LOCKED) begin
      m_tvalid                 = s_tvalid[grant_idx_reg];
      s_tready[grant_idx_reg]  = m_tready;
    end
  end

  assign busy      = busy_reg;
  assign grant_idx = grant_idx_reg;
`ifdef AXIS_ARB_TID_EN
  assign m_tid     = grant_idx_reg;
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Self-checking bench for axis_rr_packet_arbiter: vector table of single-beat arbitrations plus
// scoreboarded multi-beat sequences (round robin, backpressure, mid-packet reset, tid rotation).
module tb_axis_rr_packet_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] s_tvalid;
  logic [N-1:0] s_tready;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0] s_tkeep;
  logic [N-1:0] s_tlast;
  logic [N-1:0] s_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic [7:0]   m_tdata;
  logic [0:0]   m_tkeep;
  logic         m_tlast;
  logic [0:0]   m_tuser;
  logic         busy;
  logic [1:0]   grant_idx;
`ifdef AXIS_ARB_TID_EN
  logic [1:0]   m_tid;
`endif

  axis_rr_packet_arbiter #(.N_INPUTS(N), .TDATA_WIDTH(8), .TUSER_WIDTH(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .busy(busy), .grant_idx(grant_idx)
`ifdef AXIS_ARB_TID_EN
    , .m_tid(m_tid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    int         exp_grant;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         src;
  } beat_t;

  vec_t  vecs [8];
  beat_t exp_q [$];

  logic [7:0] src_data [N][16];
  logic       src_last [N][16];
  int         src_len [N];
  int         src_pos [N];

  int n_cmp = 0;
  int n_bad = 0;

  bit gap_en = 0;
  bit in_pkt = 0;
  bit seen_pkt = 0;
  int gap_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i]) begin
        s_tvalid[i]       = 1'b1;
        s_tdata[i*8 +: 8] = src_data[i][src_pos[i]];
        s_tlast[i]        = src_last[i][src_pos[i]];
        s_tuser[i]        = src_data[i][src_pos[i]][0];
      end else begin
        s_tvalid[i]       = 1'b0;
        s_tdata[i*8 +: 8] = 8'h00;
        s_tlast[i]        = 1'b0;
        s_tuser[i]        = 1'b0;
      end
      s_tkeep[i] = 1'b1;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    drive();
  endtask

  task automatic add_pkt(input int src, input logic [7:0] base, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      src_data[src][src_len[src]] = base + 8'(b);
      src_last[src][src_len[src]] = (b == nbeats - 1);
      src_len[src]++;
    end
  endtask

  task automatic exp_pkt(input int src, input logic [7:0] base, input int nbeats);
    beat_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.data = base + 8'(b);
      e.last = (b == nbeats - 1);
      e.src  = src;
      exp_q.push_back(e);
    end
  endtask

  // One clock: monitor at the falling edge, advance sources just after the rising edge.
  task automatic step();
    logic [N-1:0] pops;
    beat_t e;
    @(negedge clk);
    chk("tready_exclusive", 32'(s_tready & ~(4'b0001 << grant_idx)), 32'd0);
    if (m_tvalid) begin
      chk("busy_when_valid", 32'(busy), 32'd1);
      if (!in_pkt && seen_pkt && gap_en) chk("idle_gap", 32'(gap_cnt), 32'd1);
      in_pkt  = 1'b1;
      gap_cnt = 0;
    end else if (!in_pkt) begin
      gap_cnt++;
    end
    if (m_tvalid && m_tready) begin
      $display("beat src=%0d data=%02h last=%0d", grant_idx, m_tdata, m_tlast);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got data 0x%02h from %0d, expected none", m_tdata, grant_idx);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_tdata), 32'(e.data));
        chk("beat_last", 32'(m_tlast), 32'(e.last));
        chk("beat_src", 32'(grant_idx), 32'(e.src));
        chk("beat_user", 32'(m_tuser), 32'(e.data[0]));
        chk("beat_keep", 32'(m_tkeep), 32'd1);
      end
      if (m_tlast) begin
        in_pkt   = 1'b0;
        seen_pkt = 1'b1;
      end
    end
    pops = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pops[i]) src_pos[i]++;
    drive();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset(input int ncyc, input bit check);
    rst_n = 1'b0;
    clear_src();
    exp_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (check) begin
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    in_pkt = 1'b0;
    seen_pkt = 1'b0;
    gap_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Expected grants derived by hand from the rotating pointer (starts at 0, moves to winner+1).
    vecs[0] = '{4'b1111, 0};
    vecs[1] = '{4'b0001, 0};
    vecs[2] = '{4'b1000, 3};
    vecs[3] = '{4'b0110, 1};
    vecs[4] = '{4'b0011, 0};
    vecs[5] = '{4'b1100, 2};
    vecs[6] = '{4'b0111, 0};
    vecs[7] = '{4'b1010, 1};

    m_tready = 1'b1;
    rst_n = 1'b1;
    clear_src();
    #1 rst_n = 1'b0;

    // Reset then idle
    apply_reset(3, 1'b1);

    // Vector table: single-beat requests from a mask of inputs
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++) if (vecs[v].mask[i]) add_pkt(i, 8'h10 + 8'(i), 1);
      drive();
      exp_pkt(vecs[v].exp_grant, 8'h10 + 8'(vecs[v].exp_grant), 1);
      run_until_empty(10);
      clear_src();
    end

    // Single requester: 1 idle cycle then 4 back-to-back beats
    apply_reset(2, 1'b0);
    add_pkt(2, 8'hA0, 4);
    exp_pkt(2, 8'hA0, 4);
    drive();
    repeat (5) step();
    chk("single_pkt_in_5_cycles", 32'(exp_q.size()), 32'd0);
    #2;
    chk("single_busy_after_last", 32'(busy), 32'd0);
    chk("single_grant_held", 32'(grant_idx), 32'd2);
    add_pkt(0, 8'h40, 1);
    add_pkt(3, 8'h43, 1);
    drive();
    exp_pkt(3, 8'h43, 1);
    exp_pkt(0, 8'h40, 1);
    run_until_empty(20);

    // Round robin with every input continuously valid
    apply_reset(2, 1'b0);
    add_pkt(0, 8'h00, 2);
    add_pkt(0, 8'h02, 2);
    add_pkt(1, 8'h10, 2);
    add_pkt(2, 8'h20, 2);
    add_pkt(3, 8'h30, 2);
    exp_pkt(0, 8'h00, 2);
    exp_pkt(1, 8'h10, 2);
    exp_pkt(2, 8'h20, 2);
    exp_pkt(3, 8'h30, 2);
    exp_pkt(0, 8'h02, 2);
    drive();
    gap_en = 1'b1;
    run_until_empty(40);
    gap_en = 1'b0;

    // Backpressure while locked on input 1; input 0 must wait
    apply_reset(2, 1'b0);
    add_pkt(1, 8'hB0, 4);
    exp_pkt(1, 8'hB0, 4);
    drive();
    step();
    step();
    add_pkt(0, 8'hC0, 2);
    exp_pkt(0, 8'hC0, 2);
    drive();
    for (int t = 0; t < 4; t++) begin
      m_tready = (t == 0 || t == 3);
      step();
      #2;
      chk("bp_s_tready0_low", 32'(s_tready[0]), 32'd0);
      chk("bp_grant_held", 32'(grant_idx), 32'd1);
    end
    m_tready = 1'b1;
    run_until_empty(20);

    // Mid-packet reset: move pointer to 3 first, then abort input 0's packet on beat 2
    apply_reset(2, 1'b0);
    add_pkt(2, 8'h20, 1);
    exp_pkt(2, 8'h20, 1);
    drive();
    run_until_empty(10);
    add_pkt(0, 8'hD0, 5);
    exp_pkt(0, 8'hD0, 5);
    drive();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_grant_idx", 32'(grant_idx), 32'd0);
    clear_src();
    exp_q.delete();
    in_pkt = 1'b0;
    seen_pkt = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    add_pkt(1, 8'h11, 1);
    add_pkt(2, 8'h12, 1);
    add_pkt(3, 8'h13, 1);
    exp_pkt(1, 8'h11, 1);
    exp_pkt(2, 8'h12, 1);
    exp_pkt(3, 8'h13, 1);
    drive();
    run_until_empty(20);

    // Single-beat packet from input 3, then rotation back to input 0
    apply_reset(2, 1'b0);
    add_pkt(3, 8'h33, 1);
    exp_pkt(3, 8'h33, 1);
    drive();
    step();
    #2;
    chk("tid_beat_valid", 32'(m_tvalid), 32'd1);
`ifdef AXIS_ARB_TID_EN
    chk("tid_value", 32'(m_tid), 32'd3);
`endif
    run_until_empty(10);
    add_pkt(0, 8'h50, 1);
    add_pkt(1, 8'h51, 1);
    exp_pkt(0, 8'h50, 1);
    exp_pkt(1, 8'h51, 1);
    drive();
    run_until_empty(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
